// File: rtl/dmem_arbiter_pkg.sv
//==============================================================================
// Package     : dmem_pkg
// Description : Shared types and constants for the data-memory arbiter.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package dmem_pkg;

  // Arbiter sequencing states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // Requester identities
  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;

  // Default geometry
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_DEPTH  = 1025;

endpackage

`default_nettype wire

// File: rtl/dmem_arbiter_if.sv
//==============================================================================
// Interface   : dmem_arbiter_if
// Description : Request/response signals of both requesters plus the memory
//               strobe bus. slave = arbiter side, master = requester/memory.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface dmem_arbiter_if import dmem_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  // Port 0 (CPU load/store)
  logic              req0_valid;
  logic              req0_wr;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_wdata;
  logic              req0_ready;
  logic              rsp0_valid;
  logic [DATA_W-1:0] rsp0_rdata;
  logic              rsp0_err;

  // Port 1 (debug/DMA loader)
  logic              req1_valid;
  logic              req1_wr;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_wdata;
  logic              req1_ready;
  logic              rsp1_valid;
  logic [DATA_W-1:0] rsp1_rdata;
  logic              rsp1_err;

  // Single-ported memory
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_rd;
  logic              mem_wr;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  req0_valid, req0_wr, req0_addr, req0_wdata,
    output req0_ready, rsp0_valid, rsp0_rdata, rsp0_err,
    input  req1_valid, req1_wr, req1_addr, req1_wdata,
    output req1_ready, rsp1_valid, rsp1_rdata, rsp1_err,
    output mem_addr, mem_wdata, mem_rd, mem_wr,
    input  mem_rdata
  );

  modport master (
    output req0_valid, req0_wr, req0_addr, req0_wdata,
    input  req0_ready, rsp0_valid, rsp0_rdata, rsp0_err,
    output req1_valid, req1_wr, req1_addr, req1_wdata,
    input  req1_ready, rsp1_valid, rsp1_rdata, rsp1_err,
    input  mem_addr, mem_wdata, mem_rd, mem_wr,
    output mem_rdata
  );

endinterface

`default_nettype wire

// File: rtl/dmem_arbiter_rr_arb2.sv
//==============================================================================
// Module      : rr_arb2
// Description : Two-input grant logic. Round-robin on ties by default, with
//               the last winner remembered across accepts.
// Options     : DMEM_ARB_FIXED_PRI_EN - port 0 always wins ties (no history)
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module rr_arb2 import dmem_pkg::*; (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       update,
  output logic       grant_valid,
  output logic       grant
);

  assign grant_valid = |req;

`ifdef DMEM_ARB_FIXED_PRI_EN
  logic w_unused;
  assign w_unused = ^{clk, reset, update};

  // Port 0 wins whenever it is asking
  always_comb begin
    grant = req[PORT_CPU] ? PORT_CPU : PORT_DBG;
  end
`else
  logic r_last_grant;

  // Remember the winner of each accepted request; reset favours port 0 next
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_grant <= PORT_DBG;
    end else if (update) begin
      r_last_grant <= grant;
    end
  end

  // Lone requester wins; on a tie the port that did not win last time wins
  always_comb begin
    grant = PORT_CPU;
    if (req == 2'b11) begin
      grant = ~r_last_grant;
    end else if (req[PORT_DBG]) begin
      grant = PORT_DBG;
    end
  end
`endif

endmodule

`default_nettype wire

// File: rtl/dmem_arbiter.sv
//==============================================================================
// Module      : dmem_arbiter
// Description : Serialises two requesters onto one single-ported data memory.
//               Each accepted access holds the strobe MEM_LAT cycles, then a
//               one-cycle response goes back to the owner. Out-of-range
//               addresses skip the memory and answer with err.
// Options     : DMEM_ARB_FIXED_PRI_EN - fixed priority arbitration (port 0)
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module dmem_arbiter import dmem_pkg::*; #(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int MEM_LAT = 1
) (
  input  logic          clk,
  input  logic          reset,
  dmem_arbiter_if.slave bus
);

  localparam int                CNT_W      = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CNT_W-1:0]  c_cnt_init = CNT_W'(MEM_LAT - 1);
  localparam logic [ADDR_W:0]   c_depth    = (ADDR_W + 1)'(DEPTH);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic              r_wr;
  logic              r_port;
  logic              r_err;

  logic              w_grant_valid;
  logic              w_grant;
  logic              w_accept;
  logic              w_in_range;
  logic              w_last;
  logic              w_access;
  logic              w_resp;
  logic [ADDR_W-1:0] w_req_addr;
  logic [DATA_W-1:0] w_req_wdata;
  logic              w_req_wr;

  rr_arb2 u_arb (
    .clk         (clk),
    .reset       (reset),
    .req         ({bus.req1_valid, bus.req0_valid}),
    .update      (w_accept),
    .grant_valid (w_grant_valid),
    .grant       (w_grant)
  );

  // Ready is held off during reset so every output reads 0 while it is high
  assign w_accept    = (r_state == IDLE) && !reset && w_grant_valid;
  assign w_req_addr  = (w_grant == PORT_DBG) ? bus.req1_addr  : bus.req0_addr;
  assign w_req_wdata = (w_grant == PORT_DBG) ? bus.req1_wdata : bus.req0_wdata;
  assign w_req_wr    = (w_grant == PORT_DBG) ? bus.req1_wr    : bus.req0_wr;
  assign w_in_range  = {1'b0, w_req_addr} < c_depth;
  assign w_last      = (r_cnt == '0);
  assign w_access    = (r_state == ACCESS);
  assign w_resp      = (r_state == RESP);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: bad addresses bypass ACCESS and answer immediately
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_accept) w_state_nxt = w_in_range ? ACCESS : RESP;
      ACCESS:  if (w_last)   w_state_nxt = RESP;
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Latch the accepted request, count the strobe cycles, capture read data
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_wr    <= 1'b0;
      r_port  <= PORT_CPU;
      r_err   <= 1'b0;
    end else if (w_accept) begin
      r_cnt   <= c_cnt_init;
      r_addr  <= w_req_addr;
      r_wdata <= w_req_wdata;
      r_rdata <= '0;
      r_wr    <= w_req_wr;
      r_port  <= w_grant;
      r_err   <= !w_in_range;
    end else if (w_access) begin
      if (w_last) begin
        if (!r_wr) r_rdata <= bus.mem_rdata;
      end else begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  assign bus.req0_ready = w_accept && (w_grant == PORT_CPU);
  assign bus.req1_ready = w_accept && (w_grant == PORT_DBG);

  // Exactly one strobe, and only while in ACCESS
  assign bus.mem_rd    = w_access && !r_wr;
  assign bus.mem_wr    = w_access &&  r_wr;
  assign bus.mem_addr  = w_access ? r_addr  : '0;
  assign bus.mem_wdata = w_access ? r_wdata : '0;

  assign bus.rsp0_valid = w_resp && (r_port == PORT_CPU);
  assign bus.rsp0_rdata = bus.rsp0_valid ? r_rdata : '0;
  assign bus.rsp0_err   = bus.rsp0_valid && r_err;
  assign bus.rsp1_valid = w_resp && (r_port == PORT_DBG);
  assign bus.rsp1_rdata = bus.rsp1_valid ? r_rdata : '0;
  assign bus.rsp1_err   = bus.rsp1_valid && r_err;

endmodule

`default_nettype wire
